fifo_rr_source: RTL and testbench

- Per-port input FIFO that sits directly upstream of the two-port round-robin arbiter; one instance per port.
- Buffers incoming words.
- Drives the arbiter's request line (non-empty).
- Accepts the arbiter's pop strobe and presents the popped word, with a valid flag, to the downstream data mux.
- Also reports fill status and sticky error flags for flow control and debug.

---
 rtl/fifo_rr_source.sv | 94 +++++++++
 tb/tb_fifo_rr_source.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_source.sv
// Per-port input FIFO feeding one side of the two-port round-robin arbiter.
// Buffers words, raises request while non-empty, returns popped words one
// clock after the pop strobe, and reports fill status plus sticky errors.
module fifo_rr_source #(
  parameter int unsigned DATA_WIDTH      = 6,
  parameter int unsigned ADDR_WIDTH      = 3,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  request,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;

  logic pop_ok;
  logic push_ok;

  // Accept decisions; a push into a full FIFO is allowed only when a pop frees a slot.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);
  end

  // Storage array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, registered read data and sticky error flags.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_W'(1);
      end
      if (push && !push_ok) begin
        overflow_err <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_err <= 1'b1;
      end
    end
  end

  // Status flags decoded from the registered count only.
  always_comb begin
    empty        = (count == '0);
    full         = (count == CNT_W'(DEPTH));
    almost_full  = (count >= CNT_W'(ALMOST_FULL_TH));
    almost_empty = (count <= CNT_W'(ALMOST_EMPTY_TH));
    fill_level   = count;
    request      = !empty;
  end

endmodule

// File: tb/tb_fifo_rr_source.sv
// Directed bench for fifo_rr_source: fill/drain ordering, overflow and
// underflow handling, full and empty push+pop corner cases, async reset.
module tb_fifo_rr_source;

  logic       clk;
  logic       reset_L;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       request;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fill_level;
  logic       overflow_err;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  fifo_rr_source dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .request      (request),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_level   (fill_level),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic ps, input logic [5:0] d, input logic pp);
    push    = ps;
    data_in = d;
    pop     = pp;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int lvl);
    chk({tag, ".fill"},  32'(fill_level),   32'(lvl));
    chk({tag, ".empty"}, 32'(empty),        32'(lvl == 0));
    chk({tag, ".req"},   32'(request),      32'(lvl != 0));
    chk({tag, ".full"},  32'(full),         32'(lvl == 8));
    chk({tag, ".afull"}, 32'(almost_full),  32'(lvl >= 6));
    chk({tag, ".aempt"}, 32'(almost_empty), 32'(lvl <= 1));
  endtask

  initial begin
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    #1;
    chk_status("rst", 0);
    chk("rst.valid", 32'(valid_out), 0);
    chk("rst.dout",  32'(data_out), 0);
    chk("rst.ovf",   32'(overflow_err), 0);
    chk("rst.unf",   32'(underflow_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 6'(i), 1'b0);
      chk_status($sformatf("fill%0d", i), i);
      chk("fill.valid", 32'(valid_out), 0);
    end

    // Push into full FIFO is dropped
    cyc(1'b1, 6'h3F, 1'b0);
    chk_status("ovf", 8);
    chk("ovf.flag", 32'(overflow_err), 1);

    // Drain 8 words in order
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      chk($sformatf("drain%0d.dout", i), 32'(data_out), 32'(i));
      chk("drain.valid", 32'(valid_out), 1);
      chk_status($sformatf("drain%0d", i), 8 - i);
      chk("drain.ovf_sticky", 32'(overflow_err), 1);
    end
    cyc(1'b0, 6'h00, 1'b0);
    chk("idle.valid", 32'(valid_out), 0);
    chk("idle.dout_hold", 32'(data_out), 8);
    chk("idle.unf", 32'(underflow_err), 0);

    // Back-to-back pops on three words
    cyc(1'b1, 6'h0A, 1'b0);
    cyc(1'b1, 6'h0B, 1'b0);
    cyc(1'b1, 6'h0C, 1'b0);
    chk_status("b2b.load", 3);
    cyc(1'b0, 6'h00, 1'b1);
    chk("b2b1.dout", 32'(data_out), 32'h0A);
    chk("b2b1.valid", 32'(valid_out), 1);
    chk("b2b1.req", 32'(request), 1);
    cyc(1'b0, 6'h00, 1'b1);
    chk("b2b2.dout", 32'(data_out), 32'h0B);
    chk("b2b2.valid", 32'(valid_out), 1);
    cyc(1'b0, 6'h00, 1'b1);
    chk("b2b3.dout", 32'(data_out), 32'h0C);
    chk("b2b3.valid", 32'(valid_out), 1);
    chk_status("b2b3", 0);

    // Full FIFO with simultaneous push and pop; pointer wraps
    for (int i = 0; i < 8; i++) cyc(1'b1, 6'(32 + i), 1'b0);
    chk_status("full2", 8);
    cyc(1'b1, 6'h15, 1'b1);
    chk("fpp.dout", 32'(data_out), 32'h20);
    chk("fpp.valid", 32'(valid_out), 1);
    chk_status("fpp", 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      chk($sformatf("wrap%0d.dout", i), 32'(data_out), (i == 8) ? 32'h15 : 32'(32 + i));
      chk("wrap.valid", 32'(valid_out), 1);
    end
    chk_status("wrap.end", 0);
    chk("wrap.unf", 32'(underflow_err), 0);

    // Empty FIFO with simultaneous push and pop
    cyc(1'b1, 6'h2A, 1'b1);
    chk("epp.valid", 32'(valid_out), 0);
    chk("epp.unf", 32'(underflow_err), 1);
    chk_status("epp", 1);
    cyc(1'b0, 6'h00, 1'b1);
    chk("epp.pop.dout", 32'(data_out), 32'h2A);
    chk("epp.pop.valid", 32'(valid_out), 1);
    chk_status("epp.pop", 0);
    chk("epp.unf_sticky", 32'(underflow_err), 1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'(16 + i), 1'b0);
    cyc(1'b0, 6'h00, 1'b1);
    chk("pre.dout", 32'(data_out), 32'h10);
    chk("pre.valid", 32'(valid_out), 1);
    chk_status("pre", 4);
    #2;
    reset_L = 1'b0;
    #1;
    chk_status("arst", 0);
    chk("arst.valid", 32'(valid_out), 0);
    chk("arst.dout", 32'(data_out), 0);
    chk("arst.ovf", 32'(overflow_err), 0);
    chk("arst.unf", 32'(underflow_err), 0);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    chk_status("post", 0);

    // Normal operation after reset
    cyc(1'b1, 6'h11, 1'b0);
    chk_status("post.push", 1);
    cyc(1'b0, 6'h00, 1'b1);
    chk("post.dout", 32'(data_out), 32'h11);
    chk("post.valid", 32'(valid_out), 1);
    chk("post.unf", 32'(underflow_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
